// File: rtl/punc_controller.sv
// punc_controller: fetch/decode/execute control FSM for the PUnC LC3 datapath.
// Decodes the opcode in i_ir[15:12] and drives every datapath load, clear, select
// and write strobe combinationally from (state, i_ir, i_nzp_true). Also exposes
// halt status and a wrapping count of retired instructions for debug.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge) / asynchronous active-low reset
//   i_ir, i_nzp_true        instruction register contents / branch condition
//   o_pc_ld/_clr/_inc       PC load, clear, increment; o_pc_sel picks PC load data
//   o_ir_ld/_clr            IR load, clear
//   o_mem_rd/_wr            memory read strobe / write enable
//   o_mem_r_addr_sel        memory read address source
//   o_mem_w_addr_sel        memory write address source
//   o_rf_w_data_sel         register-file write data source
//   o_rf_w_addr_sel         register-file write address (R7 or ir[11:9])
//   o_rf_w_wr               register-file write enable
//   o_rf_r0_addr_sel        read port 0 address (ir[11:9] or ir[2:0])
//   o_rf_r0_rd/_r1_rd       read strobes, high when that read data is consumed
//   o_prev_ld               latch memory read data into prev
//   o_nzp_ld/_clr           condition-code load / clear
//   o_alu_sel               ALU operation; o_alu_first_val_sel ALU first operand
//   o_halted                high while parked in HALT
//   o_retired_cnt           instructions completed since reset
//
// Select encodings
//   pc_sel:          0 none, 1 PC_8_0, 2 PC_10_0, 3 RF_R1_Data
//   mem_r_addr_sel:  0 PC, 1 PC_8_0, 2 RF_R1_5_0, 3 RF_R0_Data
//   mem_w_addr_sel:  0 none, 1 PC_8_0, 2 RF_R1_5_0, 3 prev_Data
//   rf_w_data_sel:   0 ALU, 1 PC, 2 Mem_R, 3 PC_8_0
//   rf_w_addr_sel:   0 R7, 1 ir[11:9]
//   rf_r0_addr_sel:  0 ir[11:9], 1 ir[2:0]
//   alu_sel:         0 none, 1 ADD, 2 AND, 3 NOT_B
//   alu_first_val:   0 imm ir[4:0], 1 R0 read data
module punc_controller #(
  parameter logic [3:0]  HALT_OPCODE = 4'b1111,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [15:0]      i_ir,
  input  logic             i_nzp_true,
  output logic             o_pc_ld,
  output logic             o_pc_clr,
  output logic             o_pc_inc,
  output logic [1:0]       o_pc_sel,
  output logic             o_ir_ld,
  output logic             o_ir_clr,
  output logic             o_mem_rd,
  output logic             o_mem_wr,
  output logic [1:0]       o_mem_r_addr_sel,
  output logic [1:0]       o_mem_w_addr_sel,
  output logic [1:0]       o_rf_w_data_sel,
  output logic             o_rf_w_addr_sel,
  output logic             o_rf_w_wr,
  output logic             o_rf_r0_addr_sel,
  output logic             o_rf_r0_rd,
  output logic             o_rf_r1_rd,
  output logic             o_prev_ld,
  output logic             o_nzp_ld,
  output logic             o_nzp_clr,
  output logic [1:0]       o_alu_sel,
  output logic             o_alu_first_val_sel,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_retired_cnt
);

  localparam logic [3:0] OpBr  = 4'b0000, OpAdd = 4'b0001, OpLd  = 4'b0010, OpSt  = 4'b0011;
  localparam logic [3:0] OpJsr = 4'b0100, OpAnd = 4'b0101, OpLdr = 4'b0110, OpStr = 4'b0111;
  localparam logic [3:0] OpNot = 4'b1001, OpLdi = 4'b1010, OpSti = 4'b1011, OpJmp = 4'b1100;
  localparam logic [3:0] OpLea = 4'b1110;

  localparam logic [1:0] PcSel80 = 2'd1, PcSel100 = 2'd2, PcSelR1 = 2'd3;
  localparam logic [1:0] MrPc = 2'd0, MrPc80 = 2'd1, MrR150 = 2'd2, MrR0 = 2'd3;
  localparam logic [1:0] MwPc80 = 2'd1, MwR150 = 2'd2, MwPrev = 2'd3;
  localparam logic [1:0] WdAlu = 2'd0, WdPc = 2'd1, WdMem = 2'd2, WdPc80 = 2'd3;
  localparam logic       WaR7 = 1'b0, Wa119 = 1'b1;
  localparam logic       R0Sel119 = 1'b0, R0Sel20 = 1'b1;
  localparam logic [1:0] AluAdd = 2'd1, AluAnd = 2'd2, AluNot = 2'd3;
  localparam logic       FirstImm = 1'b0, FirstR0 = 1'b1;

  typedef enum logic [2:0] {StInit, StFetch, StDecode, StExec, StExec2, StHalt} state_e;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_retired_cnt;
  logic [3:0]       w_opcode;
  logic             w_retire;

  assign w_opcode = i_ir[15:12];
  // An instruction retires when its last execute cycle hands control back to FETCH.
  assign w_retire = ((r_state == StExec) && (w_state_d == StFetch)) || (r_state == StExec2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StInit;
      r_retired_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_retire) r_retired_cnt <= r_retired_cnt + CNT_W'(1);
    end
  end

  assign o_retired_cnt = r_retired_cnt;

  always_comb begin
    w_state_d           = r_state;
    o_pc_ld             = 1'b0;
    o_pc_clr            = 1'b0;
    o_pc_inc            = 1'b0;
    o_pc_sel            = 2'd0;
    o_ir_ld             = 1'b0;
    o_ir_clr            = 1'b0;
    o_mem_rd            = 1'b0;
    o_mem_wr            = 1'b0;
    o_mem_r_addr_sel    = 2'd0;
    o_mem_w_addr_sel    = 2'd0;
    o_rf_w_data_sel     = 2'd0;
    o_rf_w_addr_sel     = 1'b0;
    o_rf_w_wr           = 1'b0;
    o_rf_r0_addr_sel    = 1'b0;
    o_rf_r0_rd          = 1'b0;
    o_rf_r1_rd          = 1'b0;
    o_prev_ld           = 1'b0;
    o_nzp_ld            = 1'b0;
    o_nzp_clr           = 1'b0;
    o_alu_sel           = 2'd0;
    o_alu_first_val_sel = 1'b0;
    o_halted            = 1'b0;

    unique case (r_state)
      StInit: begin
        o_pc_clr  = 1'b1;
        o_ir_clr  = 1'b1;
        o_nzp_clr = 1'b1;
        w_state_d = StFetch;
      end
      StFetch: begin
        o_mem_rd         = 1'b1;
        o_mem_r_addr_sel = MrPc;
        o_ir_ld          = 1'b1;
        o_pc_inc         = 1'b1;
        w_state_d        = StDecode;
      end
      StDecode: begin
        w_state_d = (w_opcode == HALT_OPCODE) ? StHalt : StExec;
      end
      StExec: begin
        w_state_d = StFetch;
        case (w_opcode)
          OpAdd, OpAnd: begin
            o_alu_sel  = (w_opcode == OpAdd) ? AluAdd : AluAnd;
            o_rf_r1_rd = 1'b1;
            if (i_ir[5]) begin
              o_alu_first_val_sel = FirstImm;
            end else begin
              o_alu_first_val_sel = FirstR0;
              o_rf_r0_addr_sel    = R0Sel20;
              o_rf_r0_rd          = 1'b1;
            end
            o_rf_w_data_sel = WdAlu;
            o_rf_w_addr_sel = Wa119;
            o_rf_w_wr       = 1'b1;
            o_nzp_ld        = 1'b1;
          end
          OpNot: begin
            o_alu_sel       = AluNot;
            o_rf_r1_rd      = 1'b1;
            o_rf_w_data_sel = WdAlu;
            o_rf_w_addr_sel = Wa119;
            o_rf_w_wr       = 1'b1;
            o_nzp_ld        = 1'b1;
          end
          OpBr: begin
            o_pc_ld  = i_nzp_true;
            o_pc_sel = PcSel80;
          end
          OpJmp: begin
            o_pc_ld    = 1'b1;
            o_pc_sel   = PcSelR1;
            o_rf_r1_rd = 1'b1;
          end
          OpJsr: begin
            // R7 captures the already-incremented PC in the same edge that reloads PC.
            o_rf_w_addr_sel = WaR7;
            o_rf_w_data_sel = WdPc;
            o_rf_w_wr       = 1'b1;
            o_pc_ld         = 1'b1;
            o_pc_sel        = i_ir[11] ? PcSel100 : PcSelR1;
            o_rf_r1_rd      = ~i_ir[11];
          end
          OpLd, OpLdr: begin
            o_mem_rd         = 1'b1;
            o_mem_r_addr_sel = (w_opcode == OpLd) ? MrPc80 : MrR150;
            o_rf_r1_rd       = (w_opcode == OpLdr);
            o_rf_w_data_sel  = WdMem;
            o_rf_w_addr_sel  = Wa119;
            o_rf_w_wr        = 1'b1;
            o_nzp_ld         = 1'b1;
          end
          OpLea: begin
            o_rf_w_data_sel = WdPc80;
            o_rf_w_addr_sel = Wa119;
            o_rf_w_wr       = 1'b1;
            o_nzp_ld        = 1'b1;
          end
          OpSt, OpStr: begin
            o_mem_wr         = 1'b1;
            o_mem_w_addr_sel = (w_opcode == OpSt) ? MwPc80 : MwR150;
            o_rf_r1_rd       = (w_opcode == OpStr);
            o_rf_r0_addr_sel = R0Sel119;
            o_rf_r0_rd       = 1'b1;
          end
          OpLdi: begin
            // First hop: fetch the pointer into DR; flags wait for the final value.
            o_mem_rd         = 1'b1;
            o_mem_r_addr_sel = MrPc80;
            o_rf_w_data_sel  = WdMem;
            o_rf_w_addr_sel  = Wa119;
            o_rf_w_wr        = 1'b1;
            w_state_d        = StExec2;
          end
          OpSti: begin
            o_mem_rd         = 1'b1;
            o_mem_r_addr_sel = MrPc80;
            o_prev_ld        = 1'b1;
            w_state_d        = StExec2;
          end
          default: ;  // 1000, 1101: NOP
        endcase
      end
      StExec2: begin
        w_state_d        = StFetch;
        o_rf_r0_addr_sel = R0Sel119;
        o_rf_r0_rd       = 1'b1;
        if (w_opcode == OpLdi) begin
          // DR holds the pointer from the first hop; dereference it through read port 0.
          o_mem_rd         = 1'b1;
          o_mem_r_addr_sel = MrR0;
          o_rf_w_data_sel  = WdMem;
          o_rf_w_addr_sel  = Wa119;
          o_rf_w_wr        = 1'b1;
          o_nzp_ld         = 1'b1;
        end else begin
          o_mem_wr         = 1'b1;
          o_mem_w_addr_sel = MwPrev;
        end
      end
      StHalt: begin
        o_halted = 1'b1;
      end
      default: w_state_d = StInit;
    endcase
  end

endmodule

// File: tb/tb_punc_controller.sv
// Scoreboard bench for punc_controller: the stimulus process drives directed
// instructions and pushes the hand-written expected control word for every cycle;
// a monitor on the falling edge pops and compares against the DUT outputs.
module tb_punc_controller;

  typedef struct packed {
    logic        pc_ld, pc_clr, pc_inc;
    logic [1:0]  pc_sel;
    logic        ir_ld, ir_clr, mem_rd, mem_wr;
    logic [1:0]  mr_sel, mw_sel, wd_sel;
    logic        wa_sel, rf_wr, r0_sel, r0_rd, r1_rd, prev_ld, nzp_ld, nzp_clr;
    logic [1:0]  alu_sel;
    logic        alu_first, halted;
    logic [15:0] cnt;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ir;
  logic        nzp;
  ctl_t        act;
  logic [15:0] cnt;

  ctl_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  punc_controller dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_ir                (ir),
    .i_nzp_true          (nzp),
    .o_pc_ld             (act.pc_ld),
    .o_pc_clr            (act.pc_clr),
    .o_pc_inc            (act.pc_inc),
    .o_pc_sel            (act.pc_sel),
    .o_ir_ld             (act.ir_ld),
    .o_ir_clr            (act.ir_clr),
    .o_mem_rd            (act.mem_rd),
    .o_mem_wr            (act.mem_wr),
    .o_mem_r_addr_sel    (act.mr_sel),
    .o_mem_w_addr_sel    (act.mw_sel),
    .o_rf_w_data_sel     (act.wd_sel),
    .o_rf_w_addr_sel     (act.wa_sel),
    .o_rf_w_wr           (act.rf_wr),
    .o_rf_r0_addr_sel    (act.r0_sel),
    .o_rf_r0_rd          (act.r0_rd),
    .o_rf_r1_rd          (act.r1_rd),
    .o_prev_ld           (act.prev_ld),
    .o_nzp_ld            (act.nzp_ld),
    .o_nzp_clr           (act.nzp_clr),
    .o_alu_sel           (act.alu_sel),
    .o_alu_first_val_sel (act.alu_first),
    .o_halted            (act.halted),
    .o_retired_cnt       (act.cnt)
  );

  // Monitor: one expected control word per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  end

  task automatic step(input string nm, input ctl_t e);
    e.cnt = cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  function automatic ctl_t init_word();
    ctl_t e = '0;
    e.pc_clr = 1; e.ir_clr = 1; e.nzp_clr = 1;
    return e;
  endfunction

  task automatic fetch_decode(input string nm, input logic [15:0] instr, input logic n);
    ctl_t f = '0;
    ir = instr; nzp = n;
    f.mem_rd = 1; f.ir_ld = 1; f.pc_inc = 1;
    step({nm, "_fetch"}, f);
    step({nm, "_decode"}, '0);
  endtask

  task automatic run_instr(input string nm, input logic [15:0] instr, input logic n,
                           input ctl_t e1, input bit two, input ctl_t e2);
    fetch_decode(nm, instr, n);
    step({nm, "_exec"}, e1);
    if (two) step({nm, "_exec2"}, e2);
    cnt = cnt + 16'd1;
  endtask

  initial begin
    ctl_t e, e2;
    cnt = '0; ir = '0; nzp = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    step("reset_held", init_word());
    rst_n = 1'b1;
    step("init", init_word());

    // ADD R1,R1,#1
    e = '0; e.alu_sel = 2'd1; e.alu_first = 0; e.r1_rd = 1; e.wd_sel = 2'd0;
    e.wa_sel = 1; e.rf_wr = 1; e.nzp_ld = 1;
    run_instr("add_imm", 16'h1261, 1'b0, e, 0, '0);
    // AND R4,R2,R3 register mode
    e = '0; e.alu_sel = 2'd2; e.alu_first = 1; e.r0_sel = 1; e.r0_rd = 1; e.r1_rd = 1;
    e.wa_sel = 1; e.rf_wr = 1; e.nzp_ld = 1;
    run_instr("and_reg", 16'h5883, 1'b0, e, 0, '0);
    // NOT R4,R4
    e = '0; e.alu_sel = 2'd3; e.r1_rd = 1; e.wa_sel = 1; e.rf_wr = 1; e.nzp_ld = 1;
    run_instr("not", 16'h993F, 1'b0, e, 0, '0);
    // BRz +2 taken / not taken: pc_ld follows nzp_true
    e = '0; e.pc_ld = 1; e.pc_sel = 2'd1;
    run_instr("br_taken", 16'h0402, 1'b1, e, 0, '0);
    e = '0; e.pc_sel = 2'd1;
    run_instr("br_not_taken", 16'h0402, 1'b0, e, 0, '0);
    // JSR +4, then JMP R7, then JSRR R7
    e = '0; e.wa_sel = 0; e.wd_sel = 2'd1; e.rf_wr = 1; e.pc_ld = 1; e.pc_sel = 2'd2;
    run_instr("jsr", 16'h4804, 1'b0, e, 0, '0);
    e = '0; e.pc_ld = 1; e.pc_sel = 2'd3; e.r1_rd = 1;
    run_instr("jmp", 16'hC1C0, 1'b0, e, 0, '0);
    e = '0; e.wa_sel = 0; e.wd_sel = 2'd1; e.rf_wr = 1; e.pc_ld = 1; e.pc_sel = 2'd3;
    e.r1_rd = 1;
    run_instr("jsrr", 16'h41C0, 1'b0, e, 0, '0);
    // LD / LDR / LEA
    e = '0; e.mem_rd = 1; e.mr_sel = 2'd1; e.wd_sel = 2'd2; e.wa_sel = 1; e.rf_wr = 1;
    e.nzp_ld = 1;
    run_instr("ld", 16'h2605, 1'b0, e, 0, '0);
    e = '0; e.mem_rd = 1; e.mr_sel = 2'd2; e.r1_rd = 1; e.wd_sel = 2'd2; e.wa_sel = 1;
    e.rf_wr = 1; e.nzp_ld = 1;
    run_instr("ldr", 16'h6681, 1'b0, e, 0, '0);
    e = '0; e.wd_sel = 2'd3; e.wa_sel = 1; e.rf_wr = 1; e.nzp_ld = 1;
    run_instr("lea", 16'hE605, 1'b0, e, 0, '0);
    // ST / STR
    e = '0; e.mem_wr = 1; e.mw_sel = 2'd1; e.r0_sel = 0; e.r0_rd = 1;
    run_instr("st", 16'h3A10, 1'b0, e, 0, '0);
    e = '0; e.mem_wr = 1; e.mw_sel = 2'd2; e.r0_rd = 1; e.r1_rd = 1;
    run_instr("str", 16'h7A81, 1'b0, e, 0, '0);
    // LDI: pointer hop without flags, then dereference with flags
    e = '0; e.mem_rd = 1; e.mr_sel = 2'd1; e.wd_sel = 2'd2; e.wa_sel = 1; e.rf_wr = 1;
    e2 = '0; e2.mem_rd = 1; e2.mr_sel = 2'd3; e2.r0_sel = 0; e2.r0_rd = 1; e2.wd_sel = 2'd2;
    e2.wa_sel = 1; e2.rf_wr = 1; e2.nzp_ld = 1;
    run_instr("ldi", 16'hAC10, 1'b0, e, 1, e2);
    // STI: pointer into prev, then write R5 through it
    e = '0; e.mem_rd = 1; e.mr_sel = 2'd1; e.prev_ld = 1;
    e2 = '0; e2.mem_wr = 1; e2.mw_sel = 2'd3; e2.r0_sel = 0; e2.r0_rd = 1;
    run_instr("sti", 16'hBA10, 1'b0, e, 1, e2);
    // Unsupported opcodes behave as NOPs but still retire
    run_instr("nop_1000", 16'h8000, 1'b1, '0, 0, '0);
    run_instr("nop_1101", 16'hD000, 1'b1, '0, 0, '0);

    // HALT: parked with only halted high, counter frozen, for 100 cycles
    fetch_decode("halt", 16'hF025, 1'b1);
    e = '0; e.halted = 1;
    for (int i = 0; i < 100; i++) begin
      ir = (i % 2 == 0) ? 16'h1261 : 16'h0402;  // IR changes must not wake it
      step("halt_park", e);
    end

    // Reset exits HALT; then reset hits an LDI in EXEC2
    rst_n = 1'b0; cnt = '0;
    step("halt_reset", init_word());
    rst_n = 1'b1;
    step("reinit", init_word());
    e = '0; e.mem_rd = 1; e.mr_sel = 2'd1; e.wd_sel = 2'd2; e.wa_sel = 1; e.rf_wr = 1;
    fetch_decode("ldi_abort", 16'hAC10, 1'b0);
    step("ldi_abort_exec", e);
    rst_n = 1'b0;  // asynchronous: takes effect before the next edge
    step("mid_exec2_reset", init_word());
    rst_n = 1'b1;
    step("post_reset_init", init_word());
    e = '0; e.mem_rd = 1; e.ir_ld = 1; e.pc_inc = 1;
    step("post_reset_fetch", e);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
